// File: rtl/fuzzy_pkg.sv
// Shared types and constants for the fuzzy inference / defuzzification blocks.
package fuzzy_pkg;

  typedef logic [15:0]        mu_t;
  typedef logic signed [15:0] crisp_t;

  localparam int NUM_W     = 35;
  localparam int DEN_W     = 18;
  localparam int DIV_ITERS = 33;
  localparam int LATENCY   = 38;

  typedef enum logic [2:0] {IDLE, MAC, DIV, FIX, DONE} defuzz_state_t;

  // Applies the sign to an unsigned magnitude and clamps to the 16-bit signed range.
  function automatic crisp_t sat_crisp(input logic neg, input logic ovf,
                                       input logic [DIV_ITERS:0] mag);
    crisp_t res;
    if (neg) begin
      if (ovf || (mag > (DIV_ITERS+1)'(32768))) res = crisp_t'(16'h8000);
      else                                      res = crisp_t'(~mag[15:0] + 16'd1);
    end else begin
      if (ovf || (mag > (DIV_ITERS+1)'(32767))) res = crisp_t'(16'h7FFF);
      else                                      res = crisp_t'(mag[15:0]);
    end
    return res;
  endfunction

endpackage

// File: rtl/seq_udiv.sv
// Iterative restoring unsigned divider, one quotient bit per cycle, MSB first.
// The first iteration runs in the start cycle directly on the input operands.
module seq_udiv #(
  parameter int N_W = 33,
  parameter int D_W = 18
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N_W-1:0] dividend,
  input  logic [D_W-1:0] divisor,
  output logic           busy,
  output logic           done,
  output logic [N_W-1:0] quotient,
  output logic [D_W-1:0] remainder
);

  localparam int CNT_W = $clog2(N_W + 1);

  logic [N_W-1:0]   q_reg, q_src, q_next;
  logic [D_W-1:0]   r_reg, r_src, r_next;
  logic [D_W-1:0]   d_reg, d_src;
  logic [D_W:0]     trial;
  logic [D_W-1:0]   diff;
  logic             ge;
  logic [CNT_W-1:0] cnt;

  always_comb begin
    q_src  = start ? dividend : q_reg;
    r_src  = start ? '0 : r_reg;
    d_src  = start ? divisor : d_reg;
    trial  = {r_src, q_src[N_W-1]};
    ge     = (trial >= {1'b0, d_src});
    // When ge holds the true difference is below the divisor, so the low bits suffice.
    diff   = trial[D_W-1:0] - d_src;
    r_next = ge ? diff : trial[D_W-1:0];
    q_next = {q_src[N_W-2:0], ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg <= '0;
      r_reg <= '0;
      d_reg <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
    end else if (start) begin
      q_reg <= q_next;
      r_reg <= r_next;
      d_reg <= divisor;
      cnt   <= CNT_W'(N_W - 1);
      busy  <= 1'b1;
    end else if (busy) begin
      q_reg <= q_next;
      r_reg <= r_next;
      cnt   <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) busy <= 1'b0;
    end
  end

  assign done      = busy && (cnt == CNT_W'(1));
  assign quotient  = q_reg;
  assign remainder = r_reg;

endmodule

// File: rtl/defuzz_wavg.sv
// Zero-order Sugeno defuzzifier: y = sum(w_i*C_i) / sum(w_i) over four rules.
// Define DEFUZZ_ROUND_EN to round half away from zero instead of truncating.
module defuzz_wavg
  import fuzzy_pkg::*;
#(
  parameter crisp_t C_NN   = -16'sd16384,
  parameter crisp_t C_NP   = -16'sd8192,
  parameter crisp_t C_PN   = 16'sd8192,
  parameter crisp_t C_PP   = 16'sd16384,
  parameter crisp_t Y_ZERO = 16'sd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] w_nn,
  input  logic [15:0] w_np,
  input  logic [15:0] w_pn,
  input  logic [15:0] w_pp,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] y,
  output logic        zero_w
);

  defuzz_state_t state, state_nxt;

  mu_t                     w_q [4];
  logic [1:0]              mac_idx;
  logic signed [NUM_W-1:0] num;
  logic [DEN_W-1:0]        den;
  logic                    den_zero;
  logic                    accept;

  mu_t                     w_sel;
  crisp_t                  c_sel;
  logic signed [32:0]      prod;

  logic                    num_neg, num_ovf;
  logic [DIV_ITERS-1:0]    num_mag;
  logic                    div_start, div_busy, div_done;
  logic [DIV_ITERS-1:0]    div_quo;
  logic [DEN_W-1:0]        div_rem;
  logic [DIV_ITERS:0]      fix_mag;
  crisp_t                  y_nxt;

  assign accept    = in_valid && in_ready;
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = MAC;
      MAC:  if (mac_idx == 2'd3) state_nxt = DIV;
      DIV:  if (div_done) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_sel = w_q[mac_idx];
    case (mac_idx)
      2'd0:    c_sel = C_NN;
      2'd1:    c_sel = C_NP;
      2'd2:    c_sel = C_PN;
      default: c_sel = C_PP;
    endcase
    prod = $signed({1'b0, w_sel}) * c_sel;
  end

  // Divider works on the magnitude; the sign of num is reapplied in FIX.
  always_comb begin
    num_neg = num[NUM_W-1];
    num_ovf = num[NUM_W-1] ^ num[NUM_W-2];
    num_mag = num_neg ? (~num[DIV_ITERS-1:0] + DIV_ITERS'(1)) : num[DIV_ITERS-1:0];
  end

  assign div_start = (state == DIV) && !div_busy;

  seq_udiv #(
    .N_W (DIV_ITERS),
    .D_W (DEN_W)
  ) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .dividend  (num_mag),
    .divisor   (den),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

`ifdef DEFUZZ_ROUND_EN
  logic round_up;
  assign round_up = ({div_rem, 1'b0} >= {1'b0, den});
  assign fix_mag  = {1'b0, div_quo} + {{DIV_ITERS{1'b0}}, round_up};
`else
  logic unused_rem;
  assign unused_rem = ^div_rem;
  assign fix_mag    = {1'b0, div_quo};
`endif

  assign y_nxt = den_zero ? Y_ZERO : sat_crisp(num_neg, num_ovf, fix_mag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q      <= '{default: '0};
      mac_idx  <= '0;
      num      <= '0;
      den      <= '0;
      den_zero <= 1'b0;
      y        <= '0;
      zero_w   <= 1'b0;
    end else begin
      if (accept) begin
        w_q     <= '{w_nn, w_np, w_pn, w_pp};
        mac_idx <= '0;
        num     <= '0;
        den     <= '0;
      end
      if (state == MAC) begin
        num     <= num + NUM_W'(prod);
        den     <= den + DEN_W'(w_sel);
        mac_idx <= mac_idx + 2'd1;
      end
      if (div_start) den_zero <= (den == '0);
      if (state == FIX) begin
        y      <= y_nxt;
        zero_w <= den_zero;
      end
    end
  end

endmodule
